// File: rtl/gmii_rx_deframer.sv
// gmii_rx_deframer
//
// Receive-side GMII deframer. Strips preamble/SFD and FCS from frames arriving
// on the GMII receive pins and forwards the remaining bytes as a non-stallable
// byte stream. It also reports one status word per frame: length, error flags
// and the PTP time captured at the SFD.
//
// The optional CRC-32 check is enabled by defining GMII_RX_CRC_CHK_EN. Without
// it, no CRC logic is built and sts_err[0] is always 0.
//
// Ports:
//   gmii_rx_clk   PHY receive clock. This is the only clock.
//   gmii_rx_rst   asynchronous active-high reset
//   gmii_rxd      receive data byte
//   gmii_rxdv     receive data valid
//   gmii_rxer     receive error
//   ptp_time      free-running PTP time in the gmii_rx_clk domain
//   m_tdata       frame byte (preamble, SFD and FCS removed)
//   m_tvalid      byte valid; there is no ready, so every beat is taken
//   m_tlast       last data byte of the frame
//   sts_valid     one-cycle status pulse, coincident with m_tlast
//   sts_len       bytes after SFD including FCS, saturating at 16'hFFFF
//   sts_err       {rxer, long, short, crc}
//   sts_ts        ptp_time sampled on the SFD cycle
module gmii_rx_deframer #(
    parameter int unsigned MIN_FRAME = 64,
    parameter int unsigned MAX_FRAME = 1522,
    parameter int unsigned TS_WIDTH  = 64
) (
    input  logic                gmii_rx_clk,
    input  logic                gmii_rx_rst,
    input  logic [7:0]          gmii_rxd,
    input  logic                gmii_rxdv,
    input  logic                gmii_rxer,
    input  logic [TS_WIDTH-1:0] ptp_time,
    output logic [7:0]          m_tdata,
    output logic                m_tvalid,
    output logic                m_tlast,
    output logic                sts_valid,
    output logic [15:0]         sts_len,
    output logic [3:0]          sts_err,
    output logic [TS_WIDTH-1:0] sts_ts
);

    typedef enum logic [1:0] {
        StWaitIdle,
        StIdle,
        StPreamble,
        StData
    } state_e;

    state_e              state_q, state_d;
    // sr_q[4] holds the oldest byte. Four bytes of lag mean the FCS never leaves.
    logic [4:0][7:0]     sr_q, sr_d;
    logic [15:0]         len_q, len_d;
    logic                rxer_q, rxer_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;

    logic [7:0]          tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d;
    logic                tlast_q, tlast_d;
    logic                sts_valid_q, sts_valid_d;
    logic [15:0]         sts_len_q, sts_len_d;
    logic [3:0]          sts_err_q, sts_err_d;
    logic [TS_WIDTH-1:0] sts_ts_q, sts_ts_d;

    logic                crc_bad;

`ifdef GMII_RX_CRC_CHK_EN
    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_rev;
    logic        crc_init;
    logic        crc_en;

    // Reflected CRC-32, one byte per call
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign crc_init = (state_q == StPreamble) && gmii_rxdv && (gmii_rxd == 8'hD5);
    assign crc_en   = (state_q == StData) && gmii_rxdv;

    always_comb begin
        crc_d = crc_q;
        if (crc_init) begin
            crc_d = 32'hFFFFFFFF;
        end else if (crc_en) begin
            crc_d = crc32_byte(crc_q, gmii_rxd);
        end
    end

    // The reflected register is reversed so that the residue can be compared
    // in normal bit order.
    always_comb begin
        crc_rev = '0;
        for (int i = 0; i < 32; i++) begin
            crc_rev[i] = crc_q[31-i];
        end
    end

    assign crc_bad = (crc_rev != 32'hC704DD7B);

    always_ff @(posedge gmii_rx_clk or posedge gmii_rx_rst) begin
        if (gmii_rx_rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end
`else
    assign crc_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        len_d       = len_q;
        rxer_d      = rxer_q;
        ts_d        = ts_q;
        tdata_d     = tdata_q;
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
        sts_valid_d = 1'b0;
        sts_len_d   = sts_len_q;
        sts_err_d   = sts_err_q;
        sts_ts_d    = sts_ts_q;

        unique case (state_q)
            StWaitIdle: begin
                if (!gmii_rxdv) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (gmii_rxdv) begin
                    state_d = (gmii_rxd == 8'h55) ? StPreamble : StWaitIdle;
                end
            end
            StPreamble: begin
                if (!gmii_rxdv) begin
                    state_d = StIdle;
                end else if (gmii_rxd == 8'hD5) begin
                    state_d = StData;
                    ts_d    = ptp_time;
                    len_d   = '0;
                    rxer_d  = 1'b0;
                    sr_d    = '0;
                end else if (gmii_rxd != 8'h55) begin
                    state_d = StWaitIdle;
                end
            end
            StData: begin
                if (gmii_rxdv) begin
                    // Byte k leaves when byte k+5 arrives
                    if (len_q >= 16'd5) begin
                        tvalid_d = 1'b1;
                        tdata_d  = sr_q[4];
                    end
                    sr_d   = {sr_q[3:0], gmii_rxd};
                    len_d  = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
                    rxer_d = rxer_q | gmii_rxer;
                end else begin
                    // End of frame: the oldest held byte is the last data byte
                    if (len_q >= 16'd5) begin
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b1;
                        tdata_d  = sr_q[4];
                    end
                    sts_valid_d = 1'b1;
                    sts_len_d   = len_q;
                    sts_err_d   = {rxer_q,
                                   ({16'd0, len_q} > MAX_FRAME),
                                   ({16'd0, len_q} < MIN_FRAME),
                                   crc_bad};
                    sts_ts_d    = ts_q;
                    state_d     = StIdle;
                end
            end
            default: state_d = StWaitIdle;
        endcase
    end

    always_ff @(posedge gmii_rx_clk or posedge gmii_rx_rst) begin
        if (gmii_rx_rst) begin
            state_q     <= StWaitIdle;
            sr_q        <= '0;
            len_q       <= '0;
            rxer_q      <= 1'b0;
            ts_q        <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            sts_valid_q <= 1'b0;
            sts_len_q   <= '0;
            sts_err_q   <= '0;
            sts_ts_q    <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            len_q       <= len_d;
            rxer_q      <= rxer_d;
            ts_q        <= ts_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            sts_valid_q <= sts_valid_d;
            sts_len_q   <= sts_len_d;
            sts_err_q   <= sts_err_d;
            sts_ts_q    <= sts_ts_d;
        end
    end

    assign m_tdata   = tdata_q;
    assign m_tvalid  = tvalid_q;
    assign m_tlast   = tlast_q;
    assign sts_valid = sts_valid_q;
    assign sts_len   = sts_len_q;
    assign sts_err   = sts_err_q;
    assign sts_ts    = sts_ts_q;

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Testbench for gmii_rx_deframer.
// It applies a cycle-by-cycle vector table for short frames, then runs
// hand-written sequences for full frames, bad FCS, runt, rxer, length
// boundaries, broken preamble and reset in mid-frame.
module tb_gmii_rx_deframer;

`ifdef GMII_RX_CRC_CHK_EN
    localparam logic CRC_ON = 1'b1;
`else
    localparam logic CRC_ON = 1'b0;
`endif

    localparam logic [63:0] TBASE = 64'hA5A5_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  gmii_rxd = '0;
    logic        gmii_rxdv = 1'b0;
    logic        gmii_rxer = 1'b0;
    logic [63:0] ptp_time = '0;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        sts_valid;
    logic [15:0] sts_len;
    logic [3:0]  sts_err;
    logic [63:0] sts_ts;

    gmii_rx_deframer #(
        .MIN_FRAME(64),
        .MAX_FRAME(1522),
        .TS_WIDTH (64)
    ) dut (
        .gmii_rx_clk(clk),
        .gmii_rx_rst(rst),
        .gmii_rxd   (gmii_rxd),
        .gmii_rxdv  (gmii_rxdv),
        .gmii_rxer  (gmii_rxer),
        .ptp_time   (ptp_time),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .sts_valid  (sts_valid),
        .sts_len    (sts_len),
        .sts_err    (sts_err),
        .sts_ts     (sts_ts)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    logic [7:0]  beat_q[$];
    bit          last_q[$];
    int          sts_cnt = 0;
    logic [15:0] cap_len;
    logic [3:0]  cap_err;
    logic [63:0] cap_ts;
    logic        cap_last;

    always @(negedge clk) begin
        if (m_tvalid) begin
            beat_q.push_back(m_tdata);
            last_q.push_back(m_tlast);
        end
        if (sts_valid) begin
            sts_cnt++;
            cap_len  = sts_len;
            cap_err  = sts_err;
            cap_ts   = sts_ts;
            cap_last = m_tlast && m_tvalid;
        end
    end

    task automatic clear_mon();
        beat_q.delete();
        last_q.delete();
        sts_cnt = 0;
    endtask

    // Frame construction
    logic [7:0]  payload_q[$];
    logic [7:0]  raw_q[$];
    logic [63:0] exp_ts;

    function automatic logic [31:0] fcs_calc();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (payload_q[i]) begin
            c = c ^ {24'd0, payload_q[i]};
            for (int b = 0; b < 8; b++) begin
                if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
                else      c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic build(input int plen, input int seed, input bit corrupt);
        logic [31:0] f;
        payload_q.delete();
        raw_q.delete();
        for (int i = 0; i < plen; i++) payload_q.push_back(8'((i * 7 + seed) & 255));
        f = fcs_calc();
        if (corrupt) f[15:8] = ~f[15:8];
        raw_q = payload_q;
        for (int b = 0; b < 4; b++) raw_q.push_back(f[8*b +: 8]);
    endtask

    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        @(negedge clk);
        gmii_rxdv = dv;
        gmii_rxd  = d;
        gmii_rxer = er;
        ptp_time  = ptp_time + 64'h0000_0001_0000_0003;
    endtask

    task automatic send_preamble();
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        exp_ts = ptp_time;
    endtask

    task automatic send_raw(input int rxer_idx);
        send_preamble();
        foreach (raw_q[i]) drive(1'b1, raw_q[i], (i == rxer_idx));
        repeat (4) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_frame(input string name, input int exp_beats, input logic [15:0] exp_len,
                               input logic [3:0] exp_err);
        int bad;
        int nlast;
        bad   = 0;
        nlast = 0;
        check({name, " beats"}, 64'(beat_q.size()), 64'(exp_beats));
        foreach (beat_q[i]) begin
            if (i < payload_q.size() && beat_q[i] !== payload_q[i]) bad++;
            if (last_q[i]) nlast++;
        end
        check({name, " payload mismatches"}, 64'(bad), 64'd0);
        check({name, " tlast count"}, 64'(nlast), (exp_beats > 0) ? 64'd1 : 64'd0);
        if (exp_beats > 0 && last_q.size() > 0) check({name, " tlast on final beat"},
                                                        64'(last_q[last_q.size()-1]), 64'd1);
        check({name, " status count"}, 64'(sts_cnt), 64'd1);
        check({name, " sts_len"}, 64'(cap_len), 64'(exp_len));
        check({name, " sts_err"}, 64'(cap_err), 64'(exp_err));
        check({name, " sts_ts"}, cap_ts, exp_ts);
        check({name, " tlast with status"}, 64'(cap_last), (exp_beats > 0) ? 64'd1 : 64'd0);
    endtask

    // Cycle-by-cycle vectors: inputs, then outputs expected after that edge
    typedef struct {
        logic        dv;
        logic [7:0]  d;
        logic        er;
        logic        tv;
        logic        tl;
        logic [7:0]  td;
        logic        sv;
        logic [15:0] slen;
        logic [3:0]  serr;
        logic [63:0] sts;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    initial begin
        logic [3:0] e1;
        logic [3:0] e2;
        e1 = {3'b101, CRC_ON};
        e2 = {3'b001, CRC_ON};

        //           dv    d      er    tv    tl    td     sv    slen   serr  sts_ts
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 4'd0, 64'd0};
        vecs[1]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 4'd0, 64'd0};
        vecs[2]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 4'd0, 64'd0};
        vecs[3]  = '{1'b1, 8'hD5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 4'd0, 64'd0};
        vecs[4]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 4'd0, 64'd0};
        vecs[5]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 4'd0, 64'd0};
        vecs[6]  = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 4'd0, 64'd0};
        vecs[7]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 4'd0, 64'd0};
        vecs[8]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, 4'd0, 64'd0};
        vecs[9]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA0, 1'b0, 16'd0, 4'd0, 64'd0};
        vecs[10] = '{1'b1, 8'hA6, 1'b0, 1'b1, 1'b0, 8'hA1, 1'b0, 16'd0, 4'd0, 64'd0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b1, 16'd7, e1, TBASE + 3};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd7, e1, TBASE + 3};
        vecs[13] = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd7, e1, TBASE + 3};
        vecs[14] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd7, e1, TBASE + 3};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd7, e1, TBASE + 3};
        vecs[16] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd7, e1, TBASE + 3};
        vecs[17] = '{1'b1, 8'hD5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd7, e1, TBASE + 3};
        vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'd0, e2, TBASE + 17};
        vecs[19] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, e2, TBASE + 17};
        vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0, e2, TBASE + 17};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset m_tvalid", 64'(m_tvalid), 64'd0);
        check("reset m_tlast", 64'(m_tlast), 64'd0);
        check("reset m_tdata", 64'(m_tdata), 64'd0);
        check("reset sts_valid", 64'(sts_valid), 64'd0);
        check("reset sts_len", 64'(sts_len), 64'd0);
        check("reset sts_err", 64'(sts_err), 64'd0);
        check("reset sts_ts", sts_ts, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            gmii_rxdv = vecs[i].dv;
            gmii_rxd  = vecs[i].d;
            gmii_rxer = vecs[i].er;
            ptp_time  = TBASE + 64'(i);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d m_tvalid", i), 64'(m_tvalid), 64'(vecs[i].tv));
            check($sformatf("vec%0d m_tlast", i), 64'(m_tlast), 64'(vecs[i].tl));
            if (vecs[i].tv) check($sformatf("vec%0d m_tdata", i), 64'(m_tdata), 64'(vecs[i].td));
            check($sformatf("vec%0d sts_valid", i), 64'(sts_valid), 64'(vecs[i].sv));
            check($sformatf("vec%0d sts_len", i), 64'(sts_len), 64'(vecs[i].slen));
            check($sformatf("vec%0d sts_err", i), 64'(sts_err), 64'(vecs[i].serr));
            check($sformatf("vec%0d sts_ts", i), sts_ts, vecs[i].sts);
        end

        repeat (3) drive(1'b0, 8'h00, 1'b0);

        // Good frame
        clear_mon();
        build(60, 3, 1'b0);
        send_raw(-1);
        check_frame("good", 60, 16'd64, 4'b0000);

        // Bad FCS
        clear_mon();
        build(60, 3, 1'b1);
        send_raw(-1);
        check_frame("bad_fcs", 60, 16'd64, {3'b000, CRC_ON});

        // Runt: three bytes after SFD
        clear_mon();
        payload_q.delete();
        raw_q = '{8'h11, 8'h22, 8'h33};
        send_raw(-1);
        check_frame("runt", 0, 16'd3, {3'b001, CRC_ON});

        // RX error mid-payload
        clear_mon();
        build(96, 5, 1'b0);
        send_raw(50);
        check_frame("rxer", 96, 16'd100, 4'b1000);

        // Length boundaries
        clear_mon();
        build(59, 11, 1'b0);
        send_raw(-1);
        check_frame("len63", 59, 16'd63, 4'b0010);
        clear_mon();
        build(1518, 13, 1'b0);
        send_raw(-1);
        check_frame("len1522", 1518, 16'd1522, 4'b0000);
        clear_mon();
        build(1520, 17, 1'b0);
        send_raw(-1);
        check_frame("len1524", 1520, 16'd1524, 4'b0100);

        // Broken preamble, one idle cycle, then a good frame
        clear_mon();
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h12, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        build(60, 21, 1'b0);
        send_raw(-1);
        check_frame("after_broken", 60, 16'd64, 4'b0000);

        // Reset at payload byte 20, released while rxdv is still high
        clear_mon();
        build(60, 23, 1'b0);
        send_preamble();
        foreach (raw_q[i]) begin
            drive(1'b1, raw_q[i], 1'b0);
            if (i == 20) begin
                rst = 1'b1;
                #1;
                check("midrst m_tvalid", 64'(m_tvalid), 64'd0);
                check("midrst m_tdata", 64'(m_tdata), 64'd0);
                check("midrst sts_valid", 64'(sts_valid), 64'd0);
                check("midrst sts_len", 64'(sts_len), 64'd0);
                clear_mon();
            end
            if (i == 22) rst = 1'b0;
        end
        repeat (4) drive(1'b0, 8'h00, 1'b0);
        check("midrst beats after release", 64'(beat_q.size()), 64'd0);
        check("midrst status after release", 64'(sts_cnt), 64'd0);
        clear_mon();
        build(60, 29, 1'b0);
        send_raw(-1);
        check_frame("after_rst", 60, 16'd64, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gmii_rx_deframer.md
# gmii_rx_deframer

Receive-side GMII deframer between the GMII PHY pins (`gmii_rx_clk`/`gmii_rxd`/`gmii_rxdv`/`gmii_rxer`) and the MAC receive buffer of `mac_ptp_axi`.
- Strips preamble/SFD and FCS; emits frame bytes as a non-stallable byte stream.
- Checks length, RX error and CRC-32.
- Latches the PTP time at the SFD cycle for PTP ingress timestamping.
- Reports one status word per frame.

## Interface
Parameters:
- `MIN_FRAME`, 64, minimum legal length (bytes after SFD, FCS included)
- `MAX_FRAME`, 1522, maximum legal length
- `TS_WIDTH`, 64, PTP timestamp width

Ports:
- `gmii_rx_clk`  in  1  PHY receive clock, 125 MHz; the only clock
- `gmii_rx_rst`  in  1  reset, asynchronous, active-high
- `gmii_rxd`  in  8  receive data
- `gmii_rxdv`  in  1  receive data valid
- `gmii_rxer`  in  1  receive error
- `ptp_time`  in  TS_WIDTH  free-running PTP time, `gmii_rx_clk` domain
- `m_tdata`  out  8  frame byte (preamble, SFD, FCS removed)
- `m_tvalid`  out  1  byte valid; no ready, consumer accepts every beat
- `m_tlast`  out  1  last data byte of frame
- `sts_valid`  out  1  one-cycle status pulse
- `sts_len`  out  16  bytes after SFD incl. FCS, saturates at 16'hFFFF
- `sts_err`  out  4  [0] CRC, [1] short, [2] long, [3] rxer
- `sts_ts`  out  TS_WIDTH  `ptp_time` sampled at SFD

## Operation
States:
- **WAIT_IDLE (reset state):** stay until `gmii_rxdv`=0, then go to IDLE.
- **IDLE:**
  - `gmii_rxdv`=1 and `gmii_rxd`=8'h55: go to PREAMBLE.
  - `gmii_rxdv`=1 and any other byte: go to WAIT_IDLE.
- **PREAMBLE:**
  - 8'h55: stay (any count ≥1 accepted).
  - 8'hD5: go to DATA; latch `ptp_time` into the timestamp register.
  - Any other byte: go to WAIT_IDLE.
  - `gmii_rxdv`=0: go to IDLE.
  - No status is generated from this state.
- **DATA:**
  - Each byte sampled with `gmii_rxdv`=1 enters a 5-deep shift register.
  - Length counter increments, saturating.
  - CRC is updated.
  - `gmii_rxer`=1 sets a sticky rxer flag.
  - First cycle with `gmii_rxdv`=0: finalise the frame and go to IDLE.

Output of bytes:
- Byte k is emitted (`m_tvalid`=1, `m_tlast`=0) when byte k+5 is sampled.
- At finalise with N ≥ 5, byte N-5 is emitted with `m_tlast`=1.
- The remaining 4 held bytes are the FCS and are discarded.
- N < 5: no beats are emitted; status only.

Status:
- `sts_valid` pulses at finalise, in the same cycle as `m_tlast`.
- `sts_len`=N.
- short bit = N<`MIN_FRAME`; long bit = N>`MAX_FRAME`; rxer bit from the sticky flag.
- `sts_len`, `sts_err` and `sts_ts` hold until the next `sts_valid`.

CRC:
- CRC-32 (poly 04C11DB7, reflected, init FFFFFFFF) over all N bytes.
- Pass when the residue equals 32'hC704DD7B.

## Timing
- All outputs are registered.
- Reset values: all outputs 0; state WAIT_IDLE; shift register, counters and flags cleared.
- Data latency: byte sampled at cycle t appears on `m_tdata` at cycle t+1 if it is one of the first… more precisely, it appears the cycle after byte k+5 is sampled.
- Finalise: `gmii_rxdv`=0 sampled at cycle e; `m_tlast`/`sts_valid` asserted at e+1 for one cycle.
- Timestamp is `ptp_time` at the cycle the SFD is sampled.
- Back-to-back frames: `gmii_rxdv` may rise at cycle e+1. The new preamble produces no beat, so there is no output collision.
- Reset mid-frame:
  - Outputs clear immediately; no partial `m_tlast` or status.
  - After release, the block stays in WAIT_IDLE until `gmii_rxdv` falls.
- Length saturation: frames longer than 65535 bytes report 16'hFFFF with the long bit set; the stream continues.

## Configuration
- `GMII_RX_CRC_CHK_EN` defined: CRC-32 logic is present and `sts_err[0]` reflects the residue check.
- Undefined: no CRC logic; `sts_err[0]` is tied 0. All other behaviour is identical.

## Test plan
- **Good frame:** 7×8'h55, 8'hD5, 60 payload bytes plus valid FCS.
  - 60 beats equal to the payload, `m_tlast` on the 60th.
  - `sts_len`=64, `sts_err`=4'b0000.
  - `sts_ts` = `ptp_time` at the SFD cycle.
- **Bad FCS:** same frame with one FCS byte inverted.
  - `sts_err`=4'b0001 with `GMII_RX_CRC_CHK_EN`.
  - 4'b0000 without it.
  - Payload beats unchanged.
- **Runt:** SFD followed by 3 bytes.
  - No `m_tvalid`.
  - `sts_valid` with `sts_len`=3 and `sts_err[1]`=1.
- **RX error:** `gmii_rxer`=1 for one cycle mid-payload of a 100-byte frame.
  - `sts_err[3]`=1, `sts_len`=100, 96 beats.
- **Broken preamble:** 8'h55, 8'h12, then a good 64-byte frame after 1 idle cycle.
  - No status for the first burst.
  - Second frame as in the good-frame test.
- **Reset mid-frame:** assert `gmii_rx_rst` at payload byte 20, release while `gmii_rxdv`=1.
  - Outputs 0; no beats or status until `gmii_rxdv` falls.
  - Next frame parsed correctly.
